// File: rtl/mem_bus_sequencer_pkg.sv
// Shared definitions for the memory bus sequencer.
//   state_t        : sequencer FSM state encoding
//   BYTE_LO/BYTE_HI: byte-lane indices of a 16-bit MDR transfer
//   WAIT_W         : width of the wait-state counter
//   byte_lane()    : selects one byte of a 16-bit word by lane index
package mem_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

  localparam int WAIT_W = 4;

  function automatic logic [7:0] byte_lane(input logic [15:0] word, input logic idx);
    return (idx == BYTE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mem_bus_sequencer_if.sv
// Request, memory-bus and response signals of the memory bus sequencer.
//   master : control-store side (drives the request and the bus read data)
//   slave  : the sequencer (drives bus address/data/strobes and the response)
//
// Handshake: start is a single-cycle request pulse, honoured only while
// busy=0; ram_read/ram_write/op_16bit/addr/wdata are sampled in that same
// cycle and are don't-care at all other times. A start seen while busy=1 is
// dropped, not queued. Every accepted request ends with exactly one done
// pulse; a request with both ram_read and ram_write set is rejected with a
// one-cycle err pulse instead and never reaches the bus.
interface mem_bus_sequencer_if #(
  parameter int ADDR_W = 20
) ();

  logic              start;
  logic              ram_read;
  logic              ram_write;
  logic              op_16bit;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [7:0]        bus_data_in;

  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_data_out;
  logic              bus_data_oe;
  logic              _mem_oe;
  logic              _mem_w;
  logic              mdr_l_load;
  logic              mdr_h_load;
  logic [15:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, ram_read, ram_write, op_16bit, addr, wdata, bus_data_in,
    input  bus_addr, bus_data_out, bus_data_oe, _mem_oe, _mem_w,
           mdr_l_load, mdr_h_load, rdata, busy, done, err
  );

  modport slave (
    input  start, ram_read, ram_write, op_16bit, addr, wdata, bus_data_in,
    output bus_addr, bus_data_out, bus_data_oe, _mem_oe, _mem_w,
           mdr_l_load, mdr_h_load, rdata, busy, done, err
  );

endinterface

// File: rtl/mem_bus_sequencer_counter.sv
// Loadable down-counter used for strobe wait states.
//   clk      : clock
//   _reset   : synchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   zero     : count is zero
module mem_bus_sequencer_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: runs RAM/EPROM byte cycles for the microcode
// RAM-read / RAM-write ops. A 16-bit transfer becomes two byte cycles, low
// byte at addr and high byte at addr+1 (wrapping modulo 2^ADDR_W). Each byte
// cycle is SETUP (address/data out, strobes high), STROBE (1+WAIT_CYCLES
// cycles, _mem_oe or _mem_w low), HOLD (strobes high, MDR byte load pulse on
// reads).
//   clk       : system clock
//   _reset    : synchronous active-low reset
//   bus       : request / memory bus / response signals (slave modport)
//   dbg_state : current FSM state
module mem_bus_sequencer
  import mem_bus_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 _reset,
  mem_bus_sequencer_if.slave   bus,
  output state_t               dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state, state_n;
  logic              is_write_q;
  logic              op16_q;
  logic              byte_idx_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [7:0]        bus_data_out_q;
  logic [15:0]       rdata_q;
  logic              err_q;

  logic load_wait;
  logic dec_wait;
  logic wait_zero;
  logic both_req;
  logic any_req;

  assign both_req = bus.ram_read & bus.ram_write;
  assign any_req  = bus.ram_read | bus.ram_write;

  // Loaded with WAIT_CYCLES on the SETUP->STROBE edge, so the first STROBE
  // cycle already sees the full count and STROBE lasts 1+WAIT_CYCLES cycles.
  mem_bus_sequencer_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    ._reset   (_reset),
    .load     (load_wait),
    .load_val (WAIT_LOAD),
    .dec      (dec_wait),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    load_wait = 1'b0;
    dec_wait  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !both_req) begin
          state_n = any_req ? ST_SETUP : ST_DONE;
        end
      end
      ST_SETUP: begin
        state_n   = ST_STROBE;
        load_wait = 1'b1;
      end
      ST_STROBE: begin
        if (wait_zero) begin
          state_n = ST_HOLD;
        end else begin
          dec_wait = 1'b1;
        end
      end
      ST_HOLD: begin
        state_n = (op16_q && (byte_idx_q == BYTE_LO)) ? ST_SETUP : ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: request latch, byte-lane address/data and read capture.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      is_write_q     <= 1'b0;
      op16_q         <= 1'b0;
      byte_idx_q     <= BYTE_LO;
      base_q         <= '0;
      wdata_q        <= '0;
      bus_addr_q     <= '0;
      bus_data_out_q <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (both_req) begin
              err_q <= 1'b1;
            end else if (any_req) begin
              is_write_q <= bus.ram_write;
              op16_q     <= bus.op_16bit;
              base_q     <= bus.addr;
              wdata_q    <= bus.wdata;
              byte_idx_q <= BYTE_LO;
              bus_addr_q <= bus.addr;
              if (bus.ram_write) begin
                bus_data_out_q <= byte_lane(bus.wdata, BYTE_LO);
              end
            end
          end
        end
        ST_STROBE: begin
          // Sample the data bus at the end of the last strobe cycle.
          if (wait_zero && !is_write_q) begin
            if (byte_idx_q == BYTE_HI) begin
              rdata_q[15:8] <= bus.bus_data_in;
            end else begin
              rdata_q[7:0]  <= bus.bus_data_in;
            end
          end
        end
        ST_HOLD: begin
          if (state_n == ST_SETUP) begin
            byte_idx_q <= BYTE_HI;
            bus_addr_q <= base_q + ADDR_ONE;
            if (is_write_q) begin
              bus_data_out_q <= byte_lane(wdata_q, BYTE_HI);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes and loads decode from state only, so a reset edge drops them at once.
  assign bus._mem_oe     = !((state == ST_STROBE) && !is_write_q);
  assign bus._mem_w      = !((state == ST_STROBE) && is_write_q);
  assign bus.bus_data_oe = is_write_q &&
                           ((state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD));
  assign bus.mdr_l_load  = (state == ST_HOLD) && !is_write_q && (byte_idx_q == BYTE_LO);
  assign bus.mdr_h_load  = (state == ST_HOLD) && !is_write_q && (byte_idx_q == BYTE_HI);
  assign bus.bus_addr     = bus_addr_q;
  assign bus.bus_data_out = bus_data_out_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.err          = err_q;
  assign dbg_state        = state;

endmodule
